// File: rtl/peripheral_spram_pkg.sv
// Shared types and encodings for the peripheral single-port RAM controller.
package peripheral_spram_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } spram_state_t;

    // Low-active byte write enables: bit 0 guards the low byte, bit 1 the high byte.
    localparam logic [1:0] WEN_WORD = 2'b00;
    localparam logic [1:0] WEN_HI   = 2'b01;
    localparam logic [1:0] WEN_LO   = 2'b10;
    localparam logic [1:0] WEN_NONE = 2'b11;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/peripheral_spram_ctrl.sv
// Request-port initiator for one peripheral_spram_bb instance: zero-fills the
// RAM after reset, then serves byte/word reads and writes one at a time.
//
// state   | meaning
// --------+---------------------------------------------------------
// INIT    | zero-fill, one word per cycle, port closed
// IDLE    | req_ready high, waiting for a request
// ISSUE   | RAM chip enable low for this single cycle
// CAPTURE | read data from the RAM is registered and lane-selected
// RESP    | rsp_valid high, held until rsp_ready
module peripheral_spram_ctrl
    import peripheral_spram_pkg::*;
#(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int MEM_SIZE = 256,
    parameter int INIT_EN  = 1
) (
    input  logic          ram_clk,
    input  logic          ram_rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_size,
    input  logic [AW:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          init_done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_cen,
    output logic [1:0]    ram_wen,
    input  logic [DW-1:0] ram_dout
);

    localparam int DEPTH      = MEM_SIZE / 2;
    // The fill never runs past what ram_addr can reach.
    localparam int FILL_WORDS = (DEPTH < (1 << AW)) ? DEPTH : (1 << AW);
    localparam logic [AW-1:0] FILL_LAST = AW'(FILL_WORDS - 1);

    spram_state_t state, state_d;

    logic          req_ready_d, rsp_valid_d, rsp_err_d, init_done_d;
    logic [DW-1:0] rsp_rdata_d, ram_din_d;
    logic [AW-1:0] ram_addr_d;
    logic          ram_cen_d;
    logic [1:0]    ram_wen_d;

    // Remembered attributes of the request in flight.
    logic op_we, op_we_d;
    logic op_size, op_size_d;
    logic op_hi, op_hi_d;

    logic        accept;
    logic        req_err;
    logic [31:0] word_idx;
    logic        fill_last;

    assign accept    = req_valid && req_ready;
    assign word_idx  = 32'(req_addr[AW:1]);
    assign req_err   = ((req_size == SIZE_WORD) && req_addr[0]) || (word_idx >= 32'(DEPTH));
    // The fill has just driven its final word when the enable is low on the last address.
    assign fill_last = !ram_cen && (ram_addr == FILL_LAST);

    // State and all output registers; every output is a flop.
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            state     <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            init_done <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_cen   <= 1'b1;
            ram_wen   <= WEN_NONE;
            op_we     <= 1'b0;
            op_size   <= SIZE_BYTE;
            op_hi     <= 1'b0;
        end else begin
            state     <= state_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            init_done <= init_done_d;
            ram_addr  <= ram_addr_d;
            ram_din   <= ram_din_d;
            ram_cen   <= ram_cen_d;
            ram_wen   <= ram_wen_d;
            op_we     <= op_we_d;
            op_size   <= op_size_d;
            op_hi     <= op_hi_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_INIT:    if (fill_last) state_d = ST_IDLE;
            ST_IDLE:    if (accept) state_d = req_err ? ST_RESP : ST_ISSUE;
            ST_ISSUE:   state_d = op_we ? ST_RESP : ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    // Next values of the output registers, looking ahead to state_d so the
    // RAM strobe and handshake flags line up with the state they belong to.
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        init_done_d = init_done || (state_d != ST_INIT);
        ram_addr_d  = ram_addr;
        ram_din_d   = ram_din;
        ram_cen_d   = 1'b1;
        ram_wen_d   = WEN_NONE;
        op_we_d     = op_we;
        op_size_d   = op_size;
        op_hi_d     = op_hi;

        unique case (state)
            ST_INIT: begin
                if (state_d == ST_INIT) begin
                    ram_cen_d  = 1'b0;
                    ram_wen_d  = WEN_WORD;
                    ram_din_d  = '0;
                    // First fill cycle starts at word 0, later ones step up.
                    ram_addr_d = ram_cen ? '0 : ram_addr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    op_we_d     = req_we;
                    op_size_d   = req_size;
                    op_hi_d     = req_addr[0];
                    rsp_rdata_d = '0;
                    rsp_err_d   = req_err;
                    if (!req_err) begin
                        ram_cen_d  = 1'b0;
                        ram_addr_d = req_addr[AW:1];
                        if (!req_we) begin
                            ram_wen_d = WEN_NONE;
                        end else if (req_size == SIZE_WORD) begin
                            ram_wen_d = WEN_WORD;
                            ram_din_d = req_wdata;
                        end else begin
                            ram_wen_d = req_addr[0] ? WEN_HI : WEN_LO;
                            ram_din_d = {req_wdata[7:0], req_wdata[7:0]};
                        end
                    end
                end
            end
            ST_CAPTURE: begin
                if (op_size == SIZE_WORD) begin
                    rsp_rdata_d = ram_dout;
                end else begin
                    rsp_rdata_d = {8'h00, op_hi ? ram_dout[15:8] : ram_dout[7:0]};
                end
            end
            default: ;
        endcase
    end

endmodule
